// File: rtl/sram_responder_if.sv
// Strobe bus between the SRAM bus controller (master) and the memory-side
// responder (slave).
interface sram_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Handshake: the master holds cs_n low with either we_n or oe_n low for
    // the whole access. The slave raises ready once the access has completed
    // and keeps it high until the strobe is released. The next access may
    // begin only after ready has dropped.
    logic              cs_n;
    logic              oe_n;
    logic              we_n;
    logic              latch;
    logic              incr;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              ready;
    logic [ADDR_W-1:0] addr;

    modport master (
        output cs_n, oe_n, we_n, latch, incr, addr_in, data_in,
        input  data_out, data_oe, ready, addr
    );

    modport slave (
        input  cs_n, oe_n, we_n, latch, incr, addr_in, data_in,
        output data_out, data_oe, ready, addr
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the SRAM strobe bus: local address counter,
// fixed-latency reads, single-shot writes, level ready.
module sram_responder #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_responder_if.slave    bus,
    output logic [2:0]         state_dbg
);
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_READ_WAIT    = 3'd1,
        ST_READ_DRIVE   = 3'd2,
        ST_WRITE_COMMIT = 3'd3,
        ST_WRITE_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t            state, state_n;
    logic [3:0]        wait_cnt, wait_cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] acc_addr, acc_addr_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic [DATA_W-1:0] data_out_q, data_out_n;
    logic              data_oe_q, data_oe_n;
    logic              ready_q, ready_n;
    logic              mem_we;
    logic              rd_req, wr_req;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    assign rd_req = !bus.cs_n && !bus.oe_n;
    assign wr_req = !bus.cs_n && !bus.we_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            acc_addr   <= '0;
            wdata      <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            addr_q     <= addr_n;
            acc_addr   <= acc_addr_n;
            wdata      <= wdata_n;
            data_out_q <= data_out_n;
            data_oe_q  <= data_oe_n;
            ready_q    <= ready_n;
        end
    end

    // The array has no reset; a write caught by reset never reaches it
    // because reset forces the FSM out of WRITE_COMMIT before the next edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr] <= wdata;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    state_n = ST_WRITE_COMMIT;
                end else if (rd_req) begin
                    state_n = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (!rd_req) begin
                    state_n = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_n = ST_READ_DRIVE;
                end
            end
            ST_READ_DRIVE:   if (!rd_req) state_n = ST_IDLE;
            ST_WRITE_COMMIT: state_n = ST_WRITE_HOLD;
            ST_WRITE_HOLD:   if (!wr_req) state_n = ST_IDLE;
            default:         state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_n = wait_cnt;
        acc_addr_n = acc_addr;
        wdata_n    = wdata;
        data_out_n = data_out_q;
        data_oe_n  = data_oe_q;
        ready_n    = ready_q;
        mem_we     = 1'b0;

        // Counter runs in every state; latch beats incr.
        if (bus.latch) begin
            addr_n = bus.addr_in;
        end else if (bus.incr) begin
            addr_n = addr_q + 1'b1;
        end else begin
            addr_n = addr_q;
        end

        unique case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    acc_addr_n = addr_q;
                    wdata_n    = bus.data_in;
                end else if (rd_req) begin
                    acc_addr_n = addr_q;
                    wait_cnt_n = WAIT_INIT;
                end
            end
            ST_READ_WAIT: begin
                if (rd_req) begin
                    if (wait_cnt == 4'd0) begin
                        data_out_n = mem[acc_addr];
                        data_oe_n  = 1'b1;
                        ready_n    = 1'b1;
                    end else begin
                        wait_cnt_n = wait_cnt - 4'd1;
                    end
                end
            end
            ST_READ_DRIVE: begin
                if (!rd_req) begin
                    data_oe_n = 1'b0;
                    ready_n   = 1'b0;
                end
            end
            ST_WRITE_COMMIT: begin
                mem_we  = 1'b1;
                ready_n = 1'b1;
            end
            ST_WRITE_HOLD: begin
                if (!wr_req) begin
                    ready_n = 1'b0;
                end
            end
            default: begin
                data_oe_n = 1'b0;
                ready_n   = 1'b0;
            end
        endcase
    end

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.ready    = ready_q;
    assign bus.addr     = addr_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios with a read-data
// scoreboard fed from a reference memory image.
module tb_sram_responder;
    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int ACCESS_CYCLES = 2;
    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_READ_WAIT    = 3'd1;
    localparam logic [2:0] S_WRITE_COMMIT = 3'd3;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        state_dbg;
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];

    sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sram_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(ACCESS_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cs_n    = 1'b1;
        bus.oe_n    = 1'b1;
        bus.we_n    = 1'b1;
        bus.latch   = 1'b0;
        bus.incr    = 1'b0;
        bus.addr_in = '0;
        bus.data_in = '0;
    endtask

    task automatic set_addr(input logic [ADDR_W-1:0] a);
        bus.latch   = 1'b1;
        bus.addr_in = a;
        tick();
        bus.latch   = 1'b0;
    endtask

    task automatic pulse_incr();
        bus.incr = 1'b1;
        tick();
        bus.incr = 1'b0;
    endtask

    // Write at the current counter address; data_in is inverted during the
    // hold so a second commit would corrupt the word.
    task automatic do_write(input logic [DATA_W-1:0] d, input int hold,
                            output int lat, output logic held,
                            output logic after, output logic oe_seen);
        bus.data_in = d;
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b0;
        lat     = -1;
        oe_seen = 1'b0;
        for (int i = 1; i <= 16 && lat < 0; i++) begin
            tick();
            if (bus.data_oe !== 1'b0) oe_seen = 1'b1;
            if (bus.ready === 1'b1) lat = i;
        end
        bus.data_in = ~d;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.data_oe !== 1'b0) oe_seen = 1'b1;
        end
        held = bus.ready;
        bus.cs_n = 1'b1;
        bus.we_n = 1'b1;
        bus.oe_n = 1'b1;
        tick();
        after = bus.ready;
    endtask

    task automatic do_read(output logic [DATA_W-1:0] data, output int lat,
                           output logic rdy, output logic after_oe,
                           output logic after_rdy,
                           output logic [DATA_W-1:0] after_data);
        bus.cs_n = 1'b0;
        bus.oe_n = 1'b0;
        lat  = -1;
        data = 'x;
        rdy  = 1'bx;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (bus.data_oe === 1'b1) begin
                lat  = i;
                data = bus.data_out;
                rdy  = bus.ready;
            end
        end
        bus.cs_n = 1'b1;
        bus.oe_n = 1'b1;
        tick();
        after_oe   = bus.data_oe;
        after_rdy  = bus.ready;
        after_data = bus.data_out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] obs;
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {5'd0, bus.data_out, bus.data_oe, bus.ready, bus.addr, state_dbg};
            checks++;
            if (obs !== 32'd0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: data_out=%h oe=%b ready=%b addr=%h state=%0d, want all zero",
                         i, bus.data_out, bus.data_oe, bus.ready, bus.addr, state_dbg);
            end
        end
    endtask

    task automatic test_round_trip();
        int lat;
        logic held, after, oe_seen, rdy, a_oe, a_rdy;
        logic [DATA_W-1:0] data, a_data, exp;
        set_addr(8'h3C);
        checks++;
        if (bus.addr !== 8'h3C) begin
            failures++;
            $display("FAIL rt_latch: addr=%h want 3c", bus.addr);
        end
        do_write(8'hA5, 2, lat, held, after, oe_seen);
        model_mem[8'h3C] = 8'hA5;
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL rt_write_latency: ticks=%0d want 2", lat);
        end
        checks++;
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL rt_ready_held: ready=%b want 1", held);
        end
        checks++;
        if (after !== 1'b0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL rt_write_release: ready=%b state=%0d want 0/0", after, state_dbg);
        end
        exp_q.push_back(model_mem[8'h3C]);
        do_read(data, lat, rdy, a_oe, a_rdy, a_data);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== ACCESS_CYCLES + 1) begin
            failures++;
            $display("FAIL rt_read_latency: ticks=%0d want %0d", lat, ACCESS_CYCLES + 1);
        end
        checks++;
        if (data !== exp || rdy !== 1'b1) begin
            failures++;
            $display("FAIL rt_read_data: data=%h ready=%b want %h/1", data, rdy, exp);
        end
        checks++;
        if (a_oe !== 1'b0 || a_rdy !== 1'b0 || a_data !== exp) begin
            failures++;
            $display("FAIL rt_read_release: oe=%b ready=%b data=%h want 0/0/%h", a_oe, a_rdy, a_data, exp);
        end
    endtask

    task automatic test_counter();
        logic [ADDR_W-1:0] exp_a;
        set_addr(8'hFE);
        exp_a = 8'hFE;
        bus.incr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a = exp_a + 8'd1;
            checks++;
            if (bus.addr !== exp_a) begin
                failures++;
                $display("FAIL counter_incr step %0d: addr=%h want %h", i, bus.addr, exp_a);
            end
        end
        bus.latch   = 1'b1;
        bus.addr_in = 8'h10;
        tick();
        bus.latch = 1'b0;
        bus.incr  = 1'b0;
        checks++;
        if (bus.addr !== 8'h10) begin
            failures++;
            $display("FAIL counter_latch_priority: addr=%h want 10", bus.addr);
        end
    endtask

    task automatic test_read_abort();
        logic seen;
        logic [2:0] st_wait;
        set_addr(8'h3C);
        bus.cs_n = 1'b0;
        bus.oe_n = 1'b0;
        tick();
        st_wait = state_dbg;
        seen = bus.data_oe | bus.ready;
        bus.oe_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.data_oe !== 1'b0 || bus.ready !== 1'b0) seen = 1'b1;
        end
        bus.cs_n = 1'b1;
        checks++;
        if (st_wait !== S_READ_WAIT) begin
            failures++;
            $display("FAIL abort_entered_wait: state=%0d want %0d", st_wait, S_READ_WAIT);
        end
        checks++;
        if (seen !== 1'b0 || state_dbg !== S_IDLE) begin
            failures++;
            $display("FAIL abort_no_drive: seen=%b state=%0d want 0/0", seen, state_dbg);
        end
    endtask

    task automatic test_priority_and_reset();
        int lat;
        logic held, after, oe_seen, rdy, a_oe, a_rdy;
        logic [DATA_W-1:0] data, a_data, exp;
        logic [2:0] st;
        set_addr(8'h50);
        bus.oe_n = 1'b0;
        do_write(8'h99, 0, lat, held, after, oe_seen);
        model_mem[8'h50] = 8'h99;
        checks++;
        if (lat !== 2 || oe_seen !== 1'b0) begin
            failures++;
            $display("FAIL prio_write: ticks=%0d oe_seen=%b want 2/0", lat, oe_seen);
        end
        exp_q.push_back(model_mem[8'h50]);
        do_read(data, lat, rdy, a_oe, a_rdy, a_data);
        exp = exp_q.pop_front();
        checks++;
        if (data !== exp) begin
            failures++;
            $display("FAIL prio_readback: data=%h want %h", data, exp);
        end
        // Reset lands while the write of 0x42 sits in WRITE_COMMIT.
        bus.data_in = 8'h42;
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b0;
        tick();
        st = state_dbg;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (st !== S_WRITE_COMMIT) begin
            failures++;
            $display("FAIL rst_in_commit: state=%0d want %0d", st, S_WRITE_COMMIT);
        end
        checks++;
        if ({bus.data_out, bus.data_oe, bus.ready, bus.addr, state_dbg} !== '0) begin
            failures++;
            $display("FAIL rst_mid_op: data_out=%h oe=%b ready=%b addr=%h state=%0d want all zero",
                     bus.data_out, bus.data_oe, bus.ready, bus.addr, state_dbg);
        end
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        set_addr(8'h50);
        exp_q.push_back(model_mem[8'h50]);
        do_read(data, lat, rdy, a_oe, a_rdy, a_data);
        exp = exp_q.pop_front();
        checks++;
        if (data !== exp) begin
            failures++;
            $display("FAIL rst_write_dropped: data=%h want %h", data, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic held, after, oe_seen, rdy, a_oe, a_rdy;
        logic [DATA_W-1:0] data, a_data, exp;
        logic [DATA_W-1:0] wvals [3];
        wvals[0] = 8'h11;
        wvals[1] = 8'h22;
        wvals[2] = 8'h33;
        set_addr(8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) pulse_incr();
            do_write(wvals[i], $urandom_range(0, 2), lat, held, after, oe_seen);
            model_mem[i] = wvals[i];
        end
        set_addr(8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) pulse_incr();
            exp_q.push_back(model_mem[i]);
            do_read(data, lat, rdy, a_oe, a_rdy, a_data);
            exp = exp_q.pop_front();
            checks++;
            if (data !== exp || lat !== ACCESS_CYCLES + 1) begin
                failures++;
                $display("FAIL b2b_read %0d: data=%h ticks=%0d want %h/%0d",
                         i, data, lat, exp, ACCESS_CYCLES + 1);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_round_trip();
        test_counter();
        test_read_abort();
        test_priority_and_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the Lab 1 SRAM-style read/write strobe interface. It receives chip select, output enable, write enable, address latch and address increment from the bus controller FSM and behaves as the addressed memory: it holds a local address counter, serves reads after a fixed access delay, commits writes, and reports completion on `ready`. It is the target the controller talks to, and the bench uses it as a synthesizable memory model.

## Interface
- `ADDR_W`, 8, address counter and memory index width; depth = 2^ADDR_W words.
- `DATA_W`, 8, data word width.
- `ACCESS_CYCLES`, 2, read access delay in clocks; legal range 1..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cs_n`  in  1  chip select, active low.
- `oe_n`  in  1  output enable (read request), active low.
- `we_n`  in  1  write enable, active low.
- `latch`  in  1  load address counter from `addr_in`.
- `incr`  in  1  increment address counter.
- `addr_in`  in  ADDR_W  address loaded on `latch`.
- `data_in`  in  DATA_W  write data from controller.
- `data_out`  out  DATA_W  registered read data.
- `data_oe`  out  1  high while `data_out` is valid and driven.
- `ready`  out  1  access complete; level, held until the strobe is released.
- `addr`  out  ADDR_W  current address counter value.

## Operation
- Reset values: `data_out`=0, `data_oe`=0, `ready`=0, `addr`=0, FSM=IDLE, wait counter=0. Memory array is not cleared.
- Address counter, evaluated every edge in every state:
  - `latch`=1 loads `addr_in`.
  - Otherwise `incr`=1 adds 1 modulo 2^ADDR_W (all-ones wraps to 0).
  - `latch` has priority over `incr`.
- The access address `acc_addr` is captured from `addr` on the edge that leaves IDLE. Counter changes on that edge or later do not affect the access in flight.
- FSM states: IDLE, READ_WAIT, READ_DRIVE, WRITE_COMMIT, WRITE_HOLD.
- IDLE:
  - `cs_n`=0 and `we_n`=0: capture `data_in` and `acc_addr`, go to WRITE_COMMIT. Write wins when `oe_n` is also 0.
  - Otherwise, `cs_n`=0 and `oe_n`=0: capture `acc_addr`, load wait counter with ACCESS_CYCLES-1, go to READ_WAIT.
  - Otherwise stay.
- READ_WAIT:
  - `cs_n`=1 or `oe_n`=1: abort to IDLE; nothing is driven.
  - Otherwise, wait counter 0: `data_out` <= mem[`acc_addr`], `data_oe` <= 1, `ready` <= 1, go to READ_DRIVE.
  - Otherwise decrement the wait counter.
- READ_DRIVE: hold `data_out`, `data_oe` and `ready` while `cs_n`=0 and `oe_n`=0. On release, clear `data_oe` and `ready` and go to IDLE. `data_out` keeps its last value.
- WRITE_COMMIT: unconditionally write mem[`acc_addr`] <= captured data, set `ready`, go to WRITE_HOLD. The write commits even if `cs_n` rose in this cycle.
- WRITE_HOLD: stay while `cs_n`=0 and `we_n`=0, so a held strobe causes no second write. On release, clear `ready` and go to IDLE.
- A new access can start only from IDLE, so strobes must be released between accesses.
- Asynchronous reset mid-operation returns everything to reset values. A write still in WRITE_COMMIT when reset asserts is dropped and the memory is unchanged.

## Timing
- Read: strobe sampled at edge N in IDLE. `data_out`, `data_oe` and `ready` rise after edge N+ACCESS_CYCLES (after N+2 by default).
- Read release: `oe_n` or `cs_n` high sampled at edge M in READ_DRIVE. `data_oe` and `ready` fall after edge M.
- Write: strobe sampled at edge N. Memory is updated and `ready` rises after edge N+1. A read of that address starting at edge N+2 or later returns the new data.
- Write release: `we_n` or `cs_n` high sampled at edge M. `ready` falls after M. The earliest next access starts at edge M+1.
- Counter: `addr` reflects `latch`/`incr` one edge after it is sampled.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset then idle: `reset` pulse, all strobes high for 5 cycles -> `data_out`=0, `data_oe`=0, `ready`=0, `addr`=0 throughout.
- Write/read round trip: latch 0x3C, write 0xA5 with strobe held 3 cycles -> `ready` rises exactly 1 cycle after the start edge, a single memory write occurs; read with ACCESS_CYCLES=2 -> `data_out`=0xA5, `data_oe`=1 exactly 2 cycles after the start edge.
- Counter: latch 0xFE, incr 3 cycles -> `addr` = 0xFF, 0x00, 0x01; `latch`=1 and `incr`=1 with `addr_in`=0x10 -> `addr`=0x10.
- Read abort: start a read, raise `oe_n` after 1 cycle of READ_WAIT -> FSM returns to IDLE, `data_oe` and `ready` never assert.
- Write priority and reset mid-op: `cs_n`=`oe_n`=`we_n`=0 -> write performed, `data_oe` stays 0. Assert `reset` while in WRITE_COMMIT -> target word unchanged, all outputs at reset values.
- Back-to-back incrementing reads: write 0x11, 0x22, 0x33 to addresses 0..2, then three reads with `incr` pulsed between them -> 0x11, 0x22, 0x33 in order.
